// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, frame-buffer geometry and the 12-bit pixel type.
// Shared by the pixel pipeline and its address generator.
package vga_pkg;
    localparam int HD = 640, HF = 16, HS = 96, HB = 48, HT = HD + HF + HS + HB;
    localparam int VD = 480, VF = 10, VS = 2, VB = 33, VT = VD + VF + VS + VB;
    localparam int FB_W  = HD / 2;
    localparam int FB_H  = VD / 2;
    localparam int RGB_W = 4;
    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } rgb12_t;
endpackage

// File: rtl/vga_fb_addr_gen.sv
// vga_fb_addr_gen: maps a screen pixel (h,v) to its downscaled frame-buffer address.
// Purely combinational; counters outside the buffer map to address 0.
module vga_fb_addr_gen #(
    parameter int FB_W        = 320,
    parameter int FB_H        = 240,
    parameter int SCALE_SHIFT = 1,
    parameter int AW          = 17
) (
    input  logic [9:0]    h_cnt_i,
    input  logic [9:0]    v_cnt_i,
    output logic [AW-1:0] addr_o
);
    logic [9:0] col, row;
    always_comb begin
        col    = h_cnt_i >> SCALE_SHIFT;
        row    = v_cnt_i >> SCALE_SHIFT;
        addr_o = (row < 10'(FB_H) && col < 10'(FB_W)) ? AW'(row) * AW'(FB_W) + AW'(col) : '0;
    end
endmodule

// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: two-stage frame-buffer fetch to registered RGB with aligned syncs and a frame counter.
// Optional overlay cursor enabled by defining VGA_CURSOR_EN.
module vga_pixel_pipe
    import vga_pkg::rgb12_t;
#(
    parameter int FB_W        = vga_pkg::FB_W,
    parameter int FB_H        = vga_pkg::FB_H,
    parameter int SCALE_SHIFT = 1,
    parameter int AW          = 17
) (
    input  logic          pclk,
    input  logic          reset,
    input  logic          valid_in,
    input  logic [9:0]    h_cnt,
    input  logic [9:0]    v_cnt,
    input  logic          hsync_in,
    input  logic          vsync_in,
`ifdef VGA_CURSOR_EN
    input  logic [9:0]    cursor_x,
    input  logic [9:0]    cursor_y,
`endif
    input  logic [11:0]   fb_data,
    output logic [AW-1:0] fb_addr,
    output logic [3:0]    vga_r,
    output logic [3:0]    vga_g,
    output logic [3:0]    vga_b,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);
    logic [AW-1:0] addr, fb_addr_q, fb_addr_d;
    logic          valid_d1_q, valid_d2_q, vsync_prev_q, frame_start_q, vs_fall, cursor_on;
    logic [1:0]    hs_q, vs_q;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    rgb12_t        rgb_q, rgb_d;

    vga_fb_addr_gen #(.FB_W(FB_W), .FB_H(FB_H), .SCALE_SHIFT(SCALE_SHIFT), .AW(AW)) u_addr_gen (
        .h_cnt_i (h_cnt),
        .v_cnt_i (v_cnt),
        .addr_o  (addr)
    );

`ifdef VGA_CURSOR_EN
    logic signed [10:0] dx, dy;
    logic               cur_hit, cur_d1_q;
    always_comb begin
        dx      = $signed({1'b0, h_cnt}) - $signed({1'b0, cursor_x});
        dy      = $signed({1'b0, v_cnt}) - $signed({1'b0, cursor_y});
        cur_hit = dx >= -11'sd8 && dx <= 11'sd7 && dy >= -11'sd8 && dy <= 11'sd7;
    end
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) cur_d1_q <= 1'b0;
        else        cur_d1_q <= cur_hit;
    end
    // Blink with a 32-frame half period.
    assign cursor_on = cur_d1_q & frame_cnt_q[5];
`else
    assign cursor_on = 1'b0;
`endif

    always_comb begin
        fb_addr_d   = valid_in ? addr : '0;
        vs_fall     = vsync_prev_q & ~vsync_in;
        frame_cnt_d = frame_cnt_q + 8'(vs_fall);
        rgb_d       = !valid_d1_q ? '0 : cursor_on ? 12'hFFF : fb_data;
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            fb_addr_q     <= '0;
            valid_d1_q    <= 1'b0;
            valid_d2_q    <= 1'b0;
            hs_q          <= 2'b11;
            vs_q          <= 2'b11;
            rgb_q         <= '0;
            vsync_prev_q  <= 1'b1;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            fb_addr_q     <= fb_addr_d;
            valid_d1_q    <= valid_in;
            valid_d2_q    <= valid_d1_q;
            hs_q          <= {hs_q[0], hsync_in};
            vs_q          <= {vs_q[0], vsync_in};
            rgb_q         <= rgb_d;
            vsync_prev_q  <= vsync_in;
            frame_start_q <= vs_fall;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // rgb_q is already blanked by valid_d1; valid_d2 mirrors it as a final guard.
    assign fb_addr     = fb_addr_q;
    assign vga_r       = valid_d2_q ? rgb_q.r : 4'd0;
    assign vga_g       = valid_d2_q ? rgb_q.g : 4'd0;
    assign vga_b       = valid_d2_q ? rgb_q.b : 4'd0;
    assign hsync       = hs_q[1];
    assign vsync       = vs_q[1];
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb_vga_pixel_pipe: directed and randomized checks of vga_pixel_pipe against a per-cycle reference model.
// Define VGA_CURSOR_EN to also exercise the cursor overlay.
module tb_vga_pixel_pipe;
    logic        pclk = 1'b0;
    logic        reset, valid_in, hsync_in, vsync_in;
    logic [9:0]  h_cnt, v_cnt, cursor_x, cursor_y;
    logic [11:0] fb_data;
    logic [16:0] fb_addr;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, frame_start;
    logic [7:0]  frame_cnt;
    int          checks = 0, errors = 0;
    logic        const_mode = 1'b0;

    always #5 pclk = ~pclk;

    vga_pixel_pipe dut (
        .pclk(pclk), .reset(reset), .valid_in(valid_in), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
`ifdef VGA_CURSOR_EN
        .cursor_x(cursor_x), .cursor_y(cursor_y),
`endif
        .fb_data(fb_data), .fb_addr(fb_addr), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    // Frame-buffer model: the registered fb_addr is the memory's address register.
    function automatic logic [11:0] pix(input logic [16:0] a);
        logic [16:0] t;
        t = a ^ (a >> 5) ^ 17'h00A5A;
        return const_mode ? 12'hA5C : t[11:0];
    endfunction
    assign fb_data = pix(fb_addr);

    typedef struct packed {logic valid; logic [9:0] h; logic [9:0] v; logic hs; logic vs;} in_t;
    in_t  hist[3];
    int   exp_cnt, cnt_prev, fs_seen;
    logic prev_vs, exp_fs;

    function automatic logic [16:0] addr_of(input in_t s);
        return 17'((int'(s.v) / 2) * 320 + int'(s.h) / 2);
    endfunction

    function automatic logic in_box(input in_t s);
`ifdef VGA_CURSOR_EN
        int dx, dy;
        dx = int'(s.h) - int'(cursor_x);
        dy = int'(s.v) - int'(cursor_y);
        return dx >= -8 && dx <= 7 && dy >= -8 && dy <= 7;
`else
        return s.valid & 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int h, input int y, input logic hs, input logic vs);
        valid_in = v; h_cnt = 10'(h); v_cnt = 10'(y); hsync_in = hs; vsync_in = vs;
    endtask

    task automatic tick();
        @(posedge pclk); #1;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = '{valid_in, h_cnt, v_cnt, hsync_in, vsync_in};
        cnt_prev = exp_cnt;
        exp_fs = prev_vs && !vsync_in;
        if (exp_fs) exp_cnt = (exp_cnt + 1) % 256;
        prev_vs = vsync_in;
    endtask

    task automatic check_all(input string tag);
        logic [16:0] ea;
        logic [11:0] er;
        ea = hist[0].valid ? addr_of(hist[0]) : 17'd0;
        er = !hist[1].valid ? 12'h000 : (in_box(hist[1]) && cnt_prev[5]) ? 12'hFFF : pix(addr_of(hist[1]));
        chk({tag, "_addr"}, 32'(fb_addr), 32'(ea));
        chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'(er));
        chk({tag, "_hsync"}, 32'(hsync), 32'(hist[1].hs));
        chk({tag, "_vsync"}, 32'(vsync), 32'(hist[1].vs));
        chk({tag, "_fstart"}, 32'(frame_start), 32'(exp_fs));
        chk({tag, "_fcnt"}, 32'(frame_cnt), 32'(exp_cnt));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_addr"}, 32'(fb_addr), 0);
        chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 0);
        chk({tag, "_hsync"}, 32'(hsync), 1);
        chk({tag, "_vsync"}, 32'(vsync), 1);
        chk({tag, "_fstart"}, 32'(frame_start), 0);
        chk({tag, "_fcnt"}, 32'(frame_cnt), 0);
    endtask

    // Asserts reset mid-cycle, checks outputs go idle at once, then releases on a falling edge.
    task automatic do_reset(input string tag);
        @(negedge pclk); #2;
        reset = 1'b0;
        #1 check_idle(tag);
        for (int i = 0; i < 3; i++) hist[i] = '{1'b0, 10'd0, 10'd0, 1'b1, 1'b1};
        prev_vs = 1'b1; exp_cnt = 0; cnt_prev = 0; exp_fs = 1'b0;
        repeat (2) @(posedge pclk);
        drive(1'b0, 0, 0, 1'b1, 1'b1);
        @(negedge pclk);
        reset = 1'b1;
    endtask

    task automatic cursor_box(input string tag);
        for (int y = 40; y < 60; y++)
            for (int x = 88; x < 112; x++) begin
                drive(1'b1, x, y, 1'b1, 1'b1);
                tick(); check_all(tag);
            end
        drive(1'b0, 0, 0, 1'b1, 1'b1);
        tick(); check_all(tag);
    endtask

    initial begin
        reset = 1'b0;
        cursor_x = 10'd100; cursor_y = 10'd50;
        drive(1'b0, 0, 0, 1'b1, 1'b1);
        do_reset("rst0");
        // Idle after release
        for (int i = 0; i < 3; i++) begin
            tick(); check_idle("idle"); check_all("idle");
        end
        // Single pixel h=5,v=3 against a constant buffer
        const_mode = 1'b1;
        drive(1'b1, 5, 3, 1'b1, 1'b1);
        tick(); chk("addr_322", 32'(fb_addr), 322); check_all("px");
        drive(1'b0, 0, 0, 1'b1, 1'b1);
        tick(); chk("rgb_a5c", 32'({vga_r, vga_g, vga_b}), 32'h0A5C); check_all("px");
        const_mode = 1'b0;
        tick(); chk("rgb_off", 32'({vga_r, vga_g, vga_b}), 0); check_all("px");
        // Address corner, then valid drop
        drive(1'b1, 639, 479, 1'b1, 1'b1);
        tick(); chk("addr_max", 32'(fb_addr), 76799); check_all("corner");
        drive(1'b0, 0, 0, 1'b1, 1'b1);
        tick(); chk("rgb_max", 32'({vga_r, vga_g, vga_b}), 32'(pix(17'd76799))); check_all("corner");
        tick(); chk("rgb_drop", 32'({vga_r, vga_g, vga_b}), 0); check_all("corner");
        // Abbreviated 800x525 frame: edge lines of active video plus the vsync region
        do_reset("rst_frame");
        fs_seen = 0;
        for (int y = 0; y < 525; y++) begin
            if (!(y < 3 || (y >= 477 && y <= 481) || (y >= 488 && y <= 493) || y == 524)) continue;
            for (int x = 0; x < 800; x++) begin
                drive(x < 640 && y < 480, (x < 640 && y < 480) ? x : 0, (x < 640 && y < 480) ? y : 0,
                      !(x >= 656 && x < 752), !(y >= 490 && y < 492));
                tick(); check_all("frame");
                fs_seen += int'(frame_start);
            end
        end
        chk("frame_fs_once", 32'(fs_seen), 1);
        chk("frame_cnt1", 32'(frame_cnt), 1);
        // Randomized pixels and syncs
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
            tick(); check_all("rand");
        end
        // 256 vsync falls wrap the counter
        do_reset("rst_wrap");
        for (int i = 1; i <= 256; i++) begin
            drive(1'b0, 0, 0, 1'b1, 1'b0);
            tick(); check_all("wrap");
            drive(1'b0, 0, 0, 1'b1, 1'b1);
            tick(); check_all("wrap");
            if (i == 255) chk("wrap_255", 32'(frame_cnt), 255);
        end
        chk("wrap_0", 32'(frame_cnt), 0);
        // Held-low vsync triggers once
        fs_seen = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 0, 0, 1'b1, 1'b0);
            tick(); check_all("held");
            fs_seen += int'(frame_start);
        end
        chk("held_fs_once", 32'(fs_seen), 1);
        chk("held_cnt", 32'(frame_cnt), 1);
        // Reset mid-line during active video
        for (int x = 0; x < 20; x++) begin
            drive(1'b1, 200 + x, 100, 1'b1, 1'b1);
            tick(); check_all("midline");
        end
        do_reset("rst_mid");
        for (int i = 0; i < 4; i++) begin
            tick(); check_idle("post_rst"); check_all("post_rst");
        end
`ifdef VGA_CURSOR_EN
        do_reset("rst_cur");
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 0, 0, 1'b1, 1'b0); tick();
            drive(1'b0, 0, 0, 1'b1, 1'b1); tick();
        end
        chk("cur_cnt32", 32'(frame_cnt), 32);
        cursor_box("cur_on");
        drive(1'b1, 100, 50, 1'b1, 1'b1); tick();
        drive(1'b0, 0, 0, 1'b1, 1'b1); tick();
        chk("cur_fff", 32'({vga_r, vga_g, vga_b}), 32'h0FFF);
        do_reset("rst_cur0");
        cursor_box("cur_off");
        drive(1'b1, 100, 50, 1'b1, 1'b1); tick();
        drive(1'b0, 0, 0, 1'b1, 1'b1); tick();
        chk("cur_data", 32'({vga_r, vga_g, vga_b}), 32'(pix(17'd8050)));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
